// File: rtl/arm_pkg.sv
// Shared definitions for the register-list encoder slice.
package arm_pkg;

  localparam int REGLIST_W = 16;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } reglist_state_t;

endpackage

// File: rtl/prio_enc16.sv
// 16-input priority encoder: index of the lowest (or highest) set bit.
module prio_enc16 (
  input  logic [15:0] in,
  input  logic        msb_first,
  output logic [3:0]  idx,
  output logic        any
);

  // Scan in the direction opposite to the priority so the winning bit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx = 4'd0;
    any = |in;
    if (msb_first) begin
      for (int i = 0; i < 16; i++) begin
        if (in[i]) idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (in[i]) idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/reglist_encoder.sv
// Serialises an LDM/STM register list into one register number per accepted beat.
// Optional build macro: REGLIST_DESC_EN adds the 'descending' input (highest register first).
module reglist_encoder
  import arm_pkg::*;
#(
  parameter int NREGS = REGLIST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NREGS-1:0] reglist,
  input  logic             out_ready,
`ifdef REGLIST_DESC_EN
  input  logic             descending,
`endif
  output logic             out_valid,
  output logic [3:0]       reg_num,
  output logic [3:0]       slot,
  output logic             last,
  output logic [4:0]       count,
  output logic             busy,
  output logic             done
);

  reglist_state_t   state_q, state_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [3:0]       slot_q, slot_d;
  logic [4:0]       count_q, count_d;
  logic             desc_q, desc_d;
  logic             start_desc;
  logic [3:0]       enc_idx;
  logic             enc_any;
  logic             is_last;

  function automatic logic [4:0] popcount(input logic [NREGS-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < NREGS; i++) n = n + 5'(v[i]);
    return n;
  endfunction

`ifdef REGLIST_DESC_EN
  assign start_desc = descending;
`else
  assign start_desc = 1'b0;
`endif

  prio_enc16 u_enc (
    .in        (pending_q),
    .msb_first (desc_q),
    .idx       (enc_idx),
    .any       (enc_any)
  );

  // Exactly one bit left means the current beat closes the list.
  assign is_last = enc_any && ((pending_q & (pending_q - 1'b1)) == '0);

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    slot_d    = slot_q;
    count_d   = count_q;
    desc_d    = desc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = reglist;
          count_d   = popcount(reglist);
          slot_d    = 4'd0;
          desc_d    = start_desc;
          state_d   = (reglist != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (out_ready) begin
          pending_d = pending_q & ~(NREGS'(1) << enc_idx);
          // Slot stays at the final index on the last beat so it never wraps.
          if (is_last) state_d = DONE;
          else         slot_d  = slot_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset discards any partial list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= IDLE;
      pending_q <= '0;
      slot_q    <= 4'd0;
      count_q   <= 5'd0;
      desc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      count_q   <= count_d;
      desc_q    <= desc_d;
    end
  end

  assign out_valid = (state_q == BUSY);
  assign reg_num   = out_valid ? enc_idx : 4'd0;
  assign slot      = out_valid ? slot_q  : 4'd0;
  assign last      = out_valid && is_last;
  assign count     = count_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reglist_encoder.sv
// Directed self-checking bench for reglist_encoder.
module tb_reglist_encoder;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reglist = 16'h0;
  logic        out_ready = 1'b0;
`ifdef REGLIST_DESC_EN
  logic        descending = 1'b0;
`endif
  logic        out_valid, last, busy, done;
  logic [3:0]  reg_num, slot;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  reglist_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reglist   (reglist),
    .out_ready (out_ready),
`ifdef REGLIST_DESC_EN
    .descending(descending),
`endif
    .out_valid (out_valid),
    .reg_num   (reg_num),
    .slot      (slot),
    .last      (last),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [3:0] r, input logic [3:0] s, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".reg"},   32'(reg_num),   32'(r));
    check({tag, ".slot"},  32'(slot),      32'(s));
    check({tag, ".last"},  32'(last),      32'(l));
  endtask

  task automatic check_done(input string tag);
    check({tag, ".done"},  32'(done),      32'd1);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".reg0"},  32'(reg_num),   32'd0);
    check({tag, ".busy"},  32'(busy),      32'd1);
  endtask

  task automatic launch(input logic [15:0] list);
    start   = 1'b1;
    reglist = list;
    step();
    start   = 1'b0;
    reglist = 16'h0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.count", 32'(count),     32'd0);
    check("rst.done",  32'(done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: 0x8005 streaming, start re-asserted mid-list must be ignored
    out_ready = 1'b1;
    launch(16'h8005);
    check_beat("t1.b0", 4'd0, 4'd0, 1'b0);
    check("t1.count", 32'(count), 32'd3);
    start = 1'b1; reglist = 16'hFFFF;
    step();
    check_beat("t1.b1", 4'd2, 4'd1, 1'b0);
    start = 1'b0; reglist = 16'h0;
    step();
    check_beat("t1.b2", REG_PC, 4'd2, 1'b1);
    step();
    check_done("t1.end");
    check("t1.count_hold", 32'(count), 32'd3);
    step();
    check("t1.idle", 32'(busy), 32'd0);
    check("t1.done_pulse", 32'(done), 32'd0);

    // 2: backpressure on beat 2
    launch(16'h8005);
    check_beat("t2.b0", 4'd0, 4'd0, 1'b0);
    step();
    check_beat("t2.b1", 4'd2, 4'd1, 1'b0);
    out_ready = 1'b0;
    step();
    check_beat("t2.hold1", 4'd2, 4'd1, 1'b0);
    step();
    check_beat("t2.hold2", 4'd2, 4'd1, 1'b0);
    out_ready = 1'b1;
    step();
    check_beat("t2.b2", 4'd15, 4'd2, 1'b1);
    step();
    check_done("t2.end");
    step();

    // 3: empty list
    launch(16'h0000);
    check_done("t3.end");
    check("t3.count", 32'(count), 32'd0);
    step();
    check("t3.idle", 32'(busy), 32'd0);
    check("t3.valid", 32'(out_valid), 32'd0);

    // 4: full list
    launch(16'hFFFF);
    check("t4.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_beat($sformatf("t4.b%0d", i), 4'(i), 4'(i), (i == 15));
      step();
    end
    check_done("t4.end");
    step();

    // 5: async reset mid-list
    launch(16'h00FF);
    check_beat("t5.b0", 4'd0, 4'd0, 1'b0);
    step();
    check_beat("t5.b1", 4'd1, 4'd1, 1'b0);
    step();
    check_beat("t5.b2", 4'd2, 4'd2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5.rst_valid", 32'(out_valid), 32'd0);
    check("t5.rst_busy",  32'(busy),      32'd0);
    check("t5.rst_count", 32'(count),     32'd0);
    check("t5.rst_reg",   32'(reg_num),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5.post_idle", 32'(busy), 32'd0);
    launch(16'h0012);
    check_beat("t5.n0", 4'd1, 4'd0, 1'b0);
    check("t5.ncount", 32'(count), 32'd2);
    step();
    check_beat("t5.n1", 4'd4, 4'd1, 1'b1);
    step();
    check_done("t5.nend");
    step();

`ifdef REGLIST_DESC_EN
    // 6: descending order
    descending = 1'b1;
    launch(16'h8005);
    descending = 1'b0;
    check_beat("t6.b0", 4'd15, 4'd0, 1'b0);
    step();
    check_beat("t6.b1", 4'd2, 4'd1, 1'b0);
    step();
    check_beat("t6.b2", 4'd0, 4'd2, 1'b1);
    step();
    check_done("t6.end");
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
